// File: rtl/systolic_pkg.sv
// Shared constants for the systolic stream sequencer.
// Opcodes, FSM state encoding and drain-length helper.
package systolic_pkg;

    localparam logic [1:0] OP_LDWT = 2'b01;
    localparam logic [1:0] OP_MAC  = 2'b10;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WT_LOAD = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // Skewed partial sums need 2*DIM-1 cycles to leave the array.
    function automatic int drain_cycles(input int dim);
        return 2 * dim - 1;
    endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Loadable down-counter with zero flag.
// Times the WT_LOAD, STREAM and DRAIN phases.
module seq_cycle_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/systolic_stream_sequencer.sv
// Sequences one weight preload or MAC stream into the PE array.
// Drives buffer reads, array strobes, drain and done pulse.
module systolic_stream_sequencer
    import systolic_pkg::*;
#(
    parameter int ARRAY_DIM = 4,
    parameter int ADDR_W    = 15,
    parameter int LEN_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              buf_sel,
    output logic              array_load_wt,
    output logic              array_valid,
    output logic              acc_clear,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] WT_LD =
        LEN_W'(ARRAY_DIM - 1);
    localparam logic [LEN_W-1:0] DRAIN_LD =
        LEN_W'(drain_cycles(ARRAY_DIM) - 1);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic              accept;
    logic              rd_en;
    logic              cnt_ld;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [LEN_W-1:0]  cnt_ld_val;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        op_q;
    logic              wt_q;
    logic              val_q;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign rd_en     = (state == S_WT_LOAD) |
                       (state == S_STREAM);

    // Next state and phase-counter control.
    always_comb begin
        state_nx   = state;
        cnt_ld     = 1'b0;
        cnt_dec    = 1'b0;
        cnt_ld_val = '0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LDWT) begin
                        state_nx   = S_WT_LOAD;
                        cnt_ld     = 1'b1;
                        cnt_ld_val = WT_LD;
                    end else if (cmd_op == OP_MAC &&
                                 cmd_len != '0) begin
                        state_nx   = S_STREAM;
                        cnt_ld     = 1'b1;
                        cnt_ld_val = cmd_len - LEN_W'(1);
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_WT_LOAD: begin
                if (cnt_zero) state_nx = S_DONE;
                else          cnt_dec  = 1'b1;
            end
            S_STREAM: begin
                if (cnt_zero) begin
                    state_nx   = S_DRAIN;
                    cnt_ld     = 1'b1;
                    cnt_ld_val = DRAIN_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_zero) state_nx = S_DONE;
                else          cnt_dec  = 1'b1;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Latch command; address advances once per read, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            op_q   <= '0;
        end else if (accept) begin
            addr_q <= cmd_base_addr;
            op_q   <= cmd_op;
        end else if (rd_en) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    // Buffer data arrives one cycle after the read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_q  <= 1'b0;
            val_q <= 1'b0;
        end else begin
            wt_q  <= rd_en & (op_q == OP_LDWT);
            val_q <= rd_en & (op_q == OP_MAC);
        end
    end

    seq_cycle_counter #(
        .W(LEN_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_ld),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign buf_rd_en     = rd_en;
    assign buf_rd_addr   = rd_en ? addr_q : '0;
    assign buf_sel       = (state == S_WT_LOAD);
    assign array_load_wt = wt_q;
    assign array_valid   = val_q;
    assign acc_clear     = accept & (cmd_op == OP_MAC);
    assign busy          = ~cmd_ready;
    assign done          = (state == S_DONE);

endmodule

// File: tb/tb_systolic_stream_sequencer.sv
// Directed bench for systolic_stream_sequencer.
// Per-cycle checks against hand-derived timelines.
module tb_systolic_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [14:0] cmd_base_addr;
    logic [7:0]  cmd_len;
    logic        buf_rd_en;
    logic [14:0] buf_rd_addr;
    logic        buf_sel;
    logic        array_load_wt;
    logic        array_valid;
    logic        acc_clear;
    logic        busy;
    logic        done;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    systolic_stream_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_base_addr (cmd_base_addr),
        .cmd_len       (cmd_len),
        .buf_rd_en     (buf_rd_en),
        .buf_rd_addr   (buf_rd_addr),
        .buf_sel       (buf_sel),
        .array_load_wt (array_load_wt),
        .array_valid   (array_valid),
        .acc_clear     (acc_clear),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h",
                   tag, k, obs, exp);
        end
    endtask

    // All outputs at their idle/reset values.
    task automatic chk_idle(input string tag);
        chk({tag, " ready"}, -1, 32'(cmd_ready), 1);
        chk({tag, " busy"},  -1, 32'(busy), 0);
        chk({tag, " done"},  -1, 32'(done), 0);
        chk({tag, " rd_en"}, -1, 32'(buf_rd_en), 0);
        chk({tag, " sel"},   -1, 32'(buf_sel), 0);
        chk({tag, " ldwt"},  -1, 32'(array_load_wt), 0);
        chk({tag, " valid"}, -1, 32'(array_valid), 0);
        chk({tag, " clr"},   -1, 32'(acc_clear), 0);
    endtask

    // Offer a command in the current cycle and check every
    // cycle up to done. Accept is cycle k=0. With hold set,
    // a different command stays offered while busy.
    task automatic run_op(input string tag,
                          input logic [1:0] op,
                          input logic [14:0] base,
                          input logic [7:0] len,
                          input bit hold);
        int n;
        int lat;
        bit wt;
        bit mac;
        logic [14:0] ea;
        wt  = (op == 2'b01);
        mac = (op == 2'b10);
        n   = wt ? 4 : (mac ? int'(len) : 0);
        lat = wt ? 5 : ((mac && len != 0) ? int'(len) + 8 : 1);
        cmd_valid     = 1'b1;
        cmd_op        = op;
        cmd_base_addr = base;
        cmd_len       = len;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                if (hold) begin
                    cmd_op        = 2'b01;
                    cmd_base_addr = 15'h5555;
                    cmd_len       = 8'h33;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
            chk({tag, " ready"}, k, 32'(cmd_ready), 32'(k == 0));
            chk({tag, " busy"}, k, 32'(busy), 32'(k != 0));
            chk({tag, " clr"}, k, 32'(acc_clear),
                32'(k == 0 && mac));
            chk({tag, " rd_en"}, k, 32'(buf_rd_en),
                32'(k >= 1 && k <= n));
            chk({tag, " sel"}, k, 32'(buf_sel),
                32'(wt && k >= 1 && k <= n));
            if (k >= 1 && k <= n) begin
                ea = base + 15'(k - 1);
                chk({tag, " addr"}, k, 32'(buf_rd_addr), 32'(ea));
            end
            chk({tag, " ldwt"}, k, 32'(array_load_wt),
                32'(wt && k >= 2 && k <= n + 1));
            chk({tag, " valid"}, k, 32'(array_valid),
                32'(mac && k >= 2 && k <= n + 1));
            chk({tag, " done"}, k, 32'(done), 32'(k == lat));
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // One idle cycle with nothing offered.
    task automatic idle_cycle(input string tag);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk_idle(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_op        = 2'b00;
        cmd_base_addr = '0;
        cmd_len       = '0;
        #1;
        chk_idle("reset");
        @(negedge clk);
        chk_idle("reset hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_cycle("post reset");

        // Reset in the middle of a 10-vector stream.
        cmd_valid     = 1'b1;
        cmd_op        = 2'b10;
        cmd_base_addr = 15'h0200;
        cmd_len       = 8'd10;
        @(negedge clk);
        chk("t1 clr", 0, 32'(acc_clear), 1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            chk("t1 rd_en", k, 32'(buf_rd_en), 1);
            chk("t1 addr", k, 32'(buf_rd_addr),
                32'(15'h0200 + 15'(k - 1)));
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle("t1 async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            chk_idle("t1 after");
        end
        run_op("t1 next", 2'b01, 15'h0040, 8'd0, 1'b0);
        idle_cycle("t1 next idle");

        run_op("t2 ldwt", 2'b01, 15'h0010, 8'd0, 1'b0);
        idle_cycle("t2 idle");

        run_op("t3 mac", 2'b10, 15'h0100, 8'd6, 1'b0);
        idle_cycle("t3 idle");

        run_op("t4 wrap", 2'b10, 15'h7FFE, 8'd4, 1'b0);
        idle_cycle("t4 idle");

        run_op("t5 len0", 2'b10, 15'h0300, 8'd0, 1'b0);
        idle_cycle("t5 idle");

        run_op("t5b undef", 2'b11, 15'h0400, 8'd5, 1'b0);
        idle_cycle("t5b idle");

        // Offered command waits out a busy op, then lands
        // in the cycle right after done.
        run_op("t6 first", 2'b10, 15'h0020, 8'd3, 1'b1);
        run_op("t6 second", 2'b01, 15'h5555, 8'h33, 1'b0);
        idle_cycle("t6 idle");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
